ir_queue: RTL
=============

Name: ir_queue

Overview:
- Parametrised instruction register for the multicycle CPU, with a small prefetch queue in front of it.
- Fetch pushes instruction words into a DEPTH-entry FIFO through a valid/ready handshake.
- The controller's IRWr strobe moves the head word into the architectural instruction register (IRout).
- Registered field outputs feed the register file and control unit; flush discards all prefetched words on branches and jumps.

Parameters:
WIDTH, 32, instruction word width in bits (must be >= 32; fields decode from bits [31:0])
DEPTH, 4, prefetch queue entries (power of two, >= 2)
NOP, 32'h0000_0000, value loaded into IRout on reset and flush

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  fetch presents a word on in_data
in_data  in  WIDTH  fetched instruction word
in_ready  out  1  queue can accept a word (combinational: count < DEPTH)
IRWr  in  1  load next instruction into IRout this cycle
flush  in  1  discard queue contents and invalidate IRout
IRout  out  WIDTH  current instruction register
ir_valid  out  1  IRout holds a real (non-flushed) instruction
stall  out  1  combinational: IRWr && queue empty && !in_valid
opcode  out  6  IRout[31:26]
rs  out  5  IRout[25:21]
rt  out  5  IRout[20:16]
rd  out  5  IRout[15:11]
funct  out  6  IRout[5:0]
imm  out  16  IRout[15:0]
count  out  $clog2(DEPTH+1)  number of words queued (excludes IRout)

Behaviour:
- Reset (async, any time, including mid-operation):
  - IRout=NOP, ir_valid=0, count=0, read/write pointers=0.
  - Queue contents are don't-care.
  - in_ready=1 immediately after reset.
- Field outputs are pure slices of IRout, so they change in the same cycle IRout updates.
- Push: when in_valid && in_ready at a rising edge, in_data is written at wr_ptr, wr_ptr wraps modulo DEPTH, and count increments.
  - in_valid while in_ready=0 is ignored; fetch must hold the word.
- IRWr handling, evaluated at the rising edge:
  - Queue non-empty: IRout<=head word, ir_valid<=1, rd_ptr advances (wraps), count decrements. A simultaneous push is also accepted (net count unchanged).
  - Queue empty and in_valid=1 (bypass): IRout<=in_data, ir_valid<=1. The word is consumed and not stored, so count stays 0. in_ready is 1 here since the queue is empty.
  - Queue empty and in_valid=0: IRout holds its value, ir_valid<=0, stall=1 that cycle. The controller must retry IRWr.
- IRWr=0: IRout and ir_valid hold their values.
- Latency:
  - Word pushed at edge N into an empty queue is available to IRWr at edge N+1.
  - With bypass, the word appears in IRout at the same edge it is offered.
- Full queue: count=DEPTH, in_ready=0. IRWr in that cycle pops one word; in_ready rises the next cycle.
- Flush (synchronous, highest priority):
  - IRout<=NOP, ir_valid<=0, count<=0, rd_ptr<=wr_ptr.
  - Any push or IRWr in the same cycle is discarded, including the bypass path.
  - stall is forced to 0 while flush=1.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are determined from count only.
- No X propagation: reading an empty queue never updates IRout.

Test Plan:
- Reset mid-stream: push 3 words, assert rst asynchronously between edges -> IRout=0, ir_valid=0, count=0, in_ready=1 with no clock edge needed.
- Fill/drain with DEPTH=4: push 8C000004, 8C000008, 00221820, AC030000; 5th push held -> in_ready=0, count=4. Four IRWr -> IRout sequence matches push order. After the first pop: opcode=0x23, rs=0, rt=0, imm=0x0004.
- Simultaneous push+pop at count=2: in_valid=1 with IRWr=1 -> count stays 2, IRout=old head, new word lands at tail. Repeat across wrap (≥6 iterations) to confirm pointer wrap preserves order.
- Bypass: empty queue, in_data=00221820, in_valid=1, IRWr=1 -> next edge IRout=00221820, rd=3, funct=0x20, count=0.
- Starvation: empty queue, IRWr=1, in_valid=0 -> stall=1 combinationally; at the edge ir_valid=0 and IRout unchanged.
- Flush priority: count=3, assert flush with IRWr=1 and in_valid=1 -> next edge IRout=NOP, ir_valid=0, count=0. Next push then IRWr returns the new word, not stale data.

Source files
------------

// File: rtl/ir_queue.sv
// Instruction register with a DEPTH-entry prefetch FIFO in front of it.
// Fetch pushes words via valid/ready; IRWr moves the head word into IRout.
module ir_queue #(
    parameter int              WIDTH = 32,
    parameter int              DEPTH = 4,
    parameter logic [WIDTH-1:0] NOP  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       IRWr,
    input  logic                       flush,
    output logic [WIDTH-1:0]           IRout,
    output logic                       ir_valid,
    output logic                       stall,
    output logic [5:0]                 opcode,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [5:0]                 funct,
    output logic [15:0]                imm,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic             ir_valid_q, ir_valid_d;

    logic empty, full, store, pop, bypass;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;

    // A bypassed word goes straight to IRout, so it must not also be stored.
    assign bypass = IRWr && empty && in_valid && !flush;
    assign pop    = IRWr && !empty && !flush;
    assign store  = in_valid && in_ready && !bypass && !flush;
    assign stall  = IRWr && empty && !in_valid && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (flush) begin
            ir_d       = NOP;
            ir_valid_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                ir_d       = mem_q[rd_ptr_q];
                ir_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
            end else if (bypass) begin
                ir_d       = in_data;
                ir_valid_d = 1'b1;
            end else if (IRWr) begin
                ir_valid_d = 1'b0;
            end
            count_d = count_q + CW'(store) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign IRout    = ir_q;
    assign ir_valid = ir_valid_q;
    assign count    = count_q;
    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];

endmodule
